mask_bram_ctrl: RTL
===================

Name: mask_bram_ctrl

Overview:
- Owns the single-port 8-bit grayscale mask BRAM (IMAGE_SIZE entries).
- Sequences each frame: the mask writer stream loads the BRAM, then two downstream readers (mask apply, Hough voting) share the read path under round-robin arbitration.
- Tracks load progress, exposes mask_valid, and supports reload for the next frame's mask.

Parameters:
- WIDTH, 720, mask width in pixels
- HEIGHT, 540, mask height in pixels
- IMAGE_SIZE, WIDTH*HEIGHT, BRAM depth in entries
- ADDR_W, $clog2(IMAGE_SIZE), address width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe from mask writer; no backpressure
- wr_addr  in  ADDR_W  write address
- wr_data  in  8  grayscale mask pixel
- rd0_req  in  1  reader 0 request
- rd0_addr  in  ADDR_W  reader 0 address
- rd0_gnt  out  1  reader 0 granted this cycle
- rd0_valid  out  1  rd_data valid for reader 0
- rd1_req  in  1  reader 1 request
- rd1_addr  in  ADDR_W  reader 1 address
- rd1_gnt  out  1  reader 1 granted this cycle
- rd1_valid  out  1  rd_data valid for reader 1
- rd_data  out  8  shared read data
- reload  in  1  invalidate mask; prepare for a new load
- mask_valid  out  1  full frame loaded; reads allowed
- overflow_err  out  1  sticky; write seen while VALID
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  ADDR_W  BRAM address
- bram_wdata  out  8  BRAM write data
- bram_rdata  in  8  BRAM read data; 1-cycle latency

Behaviour:
- Reset (reset=0, async):
  - state EMPTY, write counter 0, round-robin pointer points at rd1 (so rd0 wins the first tie).
  - All outputs 0.
- FSM: EMPTY, LOADING, VALID.
  - EMPTY:
    - wr_en=1: forward the write to BRAM, counter=1, go to LOADING.
    - If IMAGE_SIZE==1, go directly to VALID instead.
  - LOADING:
    - Each wr_en forwards the write and increments the counter.
    - A write with counter==IMAGE_SIZE-1 moves the FSM to VALID on the next edge, and the counter clears.
  - VALID:
    - mask_valid=1 (registered, asserted the cycle after the final write).
    - Reads are arbitrated.
    - wr_en is dropped (bram_we=0) and sets overflow_err.
- Reload:
  - reload=1 in any state: next state EMPTY, counter 0, overflow_err cleared, mask_valid deasserts next cycle.
  - A wr_en in the same cycle as reload in EMPTY/LOADING is still forwarded to BRAM but is not counted.
  - Reload in EMPTY: no effect besides clearing overflow_err.
- BRAM write path (combinational):
  - In EMPTY/LOADING: bram_en=bram_we=wr_en, bram_addr=wr_addr, bram_wdata=wr_data.
  - Writes have absolute priority; no read is ever granted outside VALID.
- Read arbitration (VALID only, combinational grant):
  - One requester: that requester is granted.
  - Both requesting: grant the one not pointed to by the pointer; the pointer updates to the granted requester at the clock edge.
  - On grant: bram_en=1, bram_we=0, bram_addr = granted address.
  - rdX_valid is registered: it asserts exactly 1 cycle after rdX_gnt, with rd_data=bram_rdata.
  - rdX_gnt is never asserted without rdX_req. At most one grant per cycle.
  - A requester holds req/addr until granted; grant consumes exactly one request per cycle.
- Reload while reads are in flight:
  - A grant issued in the reload cycle still produces its rdX_valid next cycle.
  - No grants are issued from the following cycle onward.
- Counter width: $clog2(IMAGE_SIZE+1); never wraps.
- wr_addr is not checked unless the optional feature is compiled in.

Optional Feature:
- Macro: MASK_WR_SEQ_CHECK_EN.
- Defined:
  - Adds output seq_err (1 bit, sticky, reset/reload clear).
  - Set when a counted write has wr_addr != counter value, i.e. the raster order 0..IMAGE_SIZE-1 is violated.
  - The write is still performed.
- Undefined: port and logic absent; no address checking.

Test Plan (WIDTH=4, HEIGHT=2, IMAGE_SIZE=8):
- Reset, then 8 writes addr 0..7 data 0x10..0x17 with gaps -> mask_valid=1 exactly one cycle after the 8th write; bram_we pulses 8 times.
- VALID, rd0_req addr 3 alone -> rd0_gnt same cycle, bram_addr=3; rd0_valid next cycle with rd_data=0x13.
- VALID, rd0 and rd1 both requesting continuously (addr 1 and 6) -> grants alternate rd0, rd1, rd0...; rd_data alternates 0x11, 0x16; never two grants in one cycle.
- VALID, wr_en addr 2 data 0xFF -> bram_we=0, overflow_err=1 and stays 1; subsequent read of addr 2 returns 0x12.
- LOADING after 5 writes, reload=1 -> next cycle EMPTY, no grants on rd0_req; a new 8-write load is required before mask_valid rises; overflow_err cleared.
- Reset asserted mid-load (after 3 writes) -> all outputs 0 immediately; a full 8-write load is needed afterwards. With MASK_WR_SEQ_CHECK_EN, writes to addr 0, 1, 3 -> seq_err=1 on the third write.

Source files
------------

// File: rtl/mask_bram_ctrl_if.sv
// ============================================================================
// Module      : mask_bram_ctrl_if
// Description : Bus bundle for the mask BRAM controller: writer stream, two
//               arbitrated readers, frame control/status and the BRAM port.
//               Optional MASK_WR_SEQ_CHECK_EN adds seq_err.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface mask_bram_ctrl_if #(
  parameter int ADDR_W = 19
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  logic              rd0_req;
  logic [ADDR_W-1:0] rd0_addr;
  logic              rd0_gnt;
  logic              rd0_valid;
  logic              rd1_req;
  logic [ADDR_W-1:0] rd1_addr;
  logic              rd1_gnt;
  logic              rd1_valid;
  logic [7:0]        rd_data;

  logic              reload;
  logic              mask_valid;
  logic              overflow_err;
`ifdef MASK_WR_SEQ_CHECK_EN
  logic              seq_err;
`endif

  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [7:0]        bram_wdata;
  logic [7:0]        bram_rdata;

  // Controller side
  modport slave (
`ifdef MASK_WR_SEQ_CHECK_EN
    output seq_err,
`endif
    input  wr_en, wr_addr, wr_data,
    input  rd0_req, rd0_addr, rd1_req, rd1_addr,
    output rd0_gnt, rd0_valid, rd1_gnt, rd1_valid, rd_data,
    input  reload,
    output mask_valid, overflow_err,
    output bram_en, bram_we, bram_addr, bram_wdata,
    input  bram_rdata
  );

  // Environment side: writer, readers, frame control and the BRAM itself
  modport master (
`ifdef MASK_WR_SEQ_CHECK_EN
    input  seq_err,
`endif
    output wr_en, wr_addr, wr_data,
    output rd0_req, rd0_addr, rd1_req, rd1_addr,
    input  rd0_gnt, rd0_valid, rd1_gnt, rd1_valid, rd_data,
    output reload,
    input  mask_valid, overflow_err,
    input  bram_en, bram_we, bram_addr, bram_wdata,
    output bram_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mask_bram_ctrl.sv
// ============================================================================
// Module      : mask_bram_ctrl
// Description : Owns the single-port grayscale mask BRAM. Loads a frame from
//               the writer stream, then round-robin arbitrates two readers.
//               Optional MASK_WR_SEQ_CHECK_EN flags out-of-raster writes.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mask_bram_ctrl #(
  parameter int WIDTH      = 720,
  parameter int HEIGHT     = 540,
  parameter int IMAGE_SIZE = WIDTH * HEIGHT,
  parameter int ADDR_W     = $clog2(IMAGE_SIZE)
) (
  input  wire logic         clock,
  input  wire logic         reset,
  mask_bram_ctrl_if.slave   bus
);

  localparam int                 c_cnt_w = $clog2(IMAGE_SIZE + 1);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(IMAGE_SIZE - 1);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_LOADING = 2'd1,
    S_VALID   = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_count;
  logic                 r_rr_ptr;      // last tie winner: 0 = rd0, 1 = rd1
  logic                 r_mask_valid;
  logic                 r_overflow;
  logic                 r_rd0_valid;
  logic                 r_rd1_valid;

  logic                 w_is_valid;
  logic                 w_fwd_wr;
  logic                 w_tie;
  logic                 w_gnt0;
  logic                 w_gnt1;
  logic                 w_bram_en;
  logic                 w_bram_we;
  logic [ADDR_W-1:0]    w_bram_addr;
  logic [7:0]           w_bram_wdata;

  assign w_is_valid = (r_state == S_VALID);

  // The write path is gated by reset so the BRAM port is quiet while held in reset
  assign w_fwd_wr = reset & ~w_is_valid & bus.wr_en;

  assign w_tie  = bus.rd0_req & bus.rd1_req;
  assign w_gnt0 = w_is_valid & bus.rd0_req & (~bus.rd1_req |  r_rr_ptr);
  assign w_gnt1 = w_is_valid & bus.rd1_req & (~bus.rd0_req | ~r_rr_ptr);

  always_comb begin
    w_bram_en    = 1'b0;
    w_bram_we    = 1'b0;
    w_bram_addr  = '0;
    w_bram_wdata = '0;
    if (w_fwd_wr) begin
      w_bram_en    = 1'b1;
      w_bram_we    = 1'b1;
      w_bram_addr  = bus.wr_addr;
      w_bram_wdata = bus.wr_data;
    end else if (w_gnt0) begin
      w_bram_en    = 1'b1;
      w_bram_addr  = bus.rd0_addr;
    end else if (w_gnt1) begin
      w_bram_en    = 1'b1;
      w_bram_addr  = bus.rd1_addr;
    end
  end

  assign bus.bram_en      = w_bram_en;
  assign bus.bram_we      = w_bram_we;
  assign bus.bram_addr    = w_bram_addr;
  assign bus.bram_wdata   = w_bram_wdata;

  assign bus.rd0_gnt      = w_gnt0;
  assign bus.rd1_gnt      = w_gnt1;
  assign bus.rd0_valid    = r_rd0_valid;
  assign bus.rd1_valid    = r_rd1_valid;
  assign bus.rd_data      = (r_rd0_valid | r_rd1_valid) ? bus.bram_rdata : 8'h00;
  assign bus.mask_valid   = r_mask_valid;
  assign bus.overflow_err = r_overflow;

`ifdef MASK_WR_SEQ_CHECK_EN
  logic r_seq_err;
  logic w_counted;

  assign w_counted   = ~w_is_valid & bus.wr_en & ~bus.reload;
  assign bus.seq_err = r_seq_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_seq_err <= 1'b0;
    end else if (bus.reload) begin
      r_seq_err <= 1'b0;
    end else if (w_counted && (c_cnt_w'(bus.wr_addr) != r_count)) begin
      r_seq_err <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_EMPTY;
      r_count      <= '0;
      r_rr_ptr     <= 1'b1;
      r_mask_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_rd0_valid  <= 1'b0;
      r_rd1_valid  <= 1'b0;
    end else begin
      r_rd0_valid <= w_gnt0;
      r_rd1_valid <= w_gnt1;
      // Fairness pointer only moves when both readers contend
      if (w_is_valid && w_tie) begin
        r_rr_ptr <= w_gnt1;
      end

      if (bus.reload) begin
        r_state      <= S_EMPTY;
        r_count      <= '0;
        r_mask_valid <= 1'b0;
        r_overflow   <= 1'b0;
      end else begin
        case (r_state)
          S_EMPTY: begin
            if (bus.wr_en) begin
              if (IMAGE_SIZE == 1) begin
                r_state      <= S_VALID;
                r_mask_valid <= 1'b1;
                r_count      <= '0;
              end else begin
                r_state      <= S_LOADING;
                r_count      <= c_cnt_w'(1);
              end
            end
          end
          S_LOADING: begin
            if (bus.wr_en) begin
              if (r_count == c_last) begin
                r_state      <= S_VALID;
                r_mask_valid <= 1'b1;
                r_count      <= '0;
              end else begin
                r_count      <= r_count + c_cnt_w'(1);
              end
            end
          end
          S_VALID: begin
            if (bus.wr_en) begin
              r_overflow <= 1'b1;
            end
          end
          default: begin
            r_state      <= S_EMPTY;
            r_count      <= '0;
            r_mask_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
